// File: rtl/alarm_timer.sv
// ============================================================================
// alarm_timer : parameter store, 1 Hz tick and one-shot countdown that feeds
//               the anti-theft FSM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alarm_timer #(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter logic [3:0]  T_ARM_DEF = 4'd6,
  parameter logic [3:0]  T_DRV_DEF = 4'd8,
  parameter logic [3:0]  T_PAS_DEF = 4'd15,
  parameter logic [3:0]  T_ALM_DEF = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic       one_hz_enable,
  output logic       running,
  output logic [3:0] time_left
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic [3:0]    time_left_q, time_left_d;
  logic [3:0]    param_q [4];
  logic [3:0]    param_d [4];

  logic          load;
  logic          wrap;
  logic [3:0]    load_value;

  // Reprogram wins over start, so a load only happens when reprogram is low.
  assign load       = start_timer && !reprogram;
  assign wrap       = (pre_q == PRE_MAX);
  assign load_value = param_q[interval];

  always_comb begin
    param_d = param_q;
    if (reprogram) begin
      param_d[time_param_sel] = time_value;
    end
  end

  // The countdown steps on the wrap edge itself, the same edge that raises
  // one_hz_enable, which gives exactly N*CLK_HZ cycles from load to expiry.
  always_comb begin
    pre_d  = pre_q + 1'b1;
    tick_d = 1'b0;
    if (load) begin
      pre_d = '0;
    end else if (wrap) begin
      pre_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    if (reprogram) begin
      state_d     = IDLE;
      time_left_d = 4'd0;
    end else if (start_timer) begin
      time_left_d = load_value;
      state_d     = (load_value == 4'd0) ? DONE : COUNT;
    end else begin
      case (state_q)
        COUNT: begin
          if (wrap) begin
            if (time_left_q > 4'd1) begin
              time_left_d = time_left_q - 4'd1;
            end else begin
              time_left_d = 4'd0;
              state_d     = DONE;
            end
          end
        end
        DONE: begin
          time_left_d = 4'd0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pre_q       <= '0;
      tick_q      <= 1'b0;
      time_left_q <= 4'd0;
      param_q[0]  <= T_ARM_DEF;
      param_q[1]  <= T_DRV_DEF;
      param_q[2]  <= T_PAS_DEF;
      param_q[3]  <= T_ALM_DEF;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      tick_q      <= tick_d;
      time_left_q <= time_left_d;
      param_q     <= param_d;
    end
  end

  assign expired       = (state_q == DONE);
  assign running       = (state_q == COUNT);
  assign one_hz_enable = tick_q;
  assign time_left     = time_left_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_timer.sv
// ============================================================================
// tb_alarm_timer : directed bench for alarm_timer with CLK_HZ = 4.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_alarm_timer;

  logic       clock;
  logic       reset;
  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       one_hz_enable;
  logic       running;
  logic [3:0] time_left;

  int checks = 0;
  int errors = 0;

  alarm_timer #(
    .CLK_HZ(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_timer   (start_timer),
    .interval      (interval),
    .reprogram     (reprogram),
    .time_param_sel(time_param_sel),
    .time_value    (time_value),
    .expired       (expired),
    .one_hz_enable (one_hz_enable),
    .running       (running),
    .time_left     (time_left)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n active edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Edges from the load edge until expired rises; 0 if it never does.
  task automatic wait_expired(input int budget, output int n);
    n = 0;
    for (int k = 1; k <= budget; k++) begin
      step(1);
      if (expired) begin
        n = k;
        break;
      end
    end
  endtask

  int n;

  initial begin
    reset          = 1'b1;
    start_timer    = 1'b0;
    interval       = 2'd0;
    reprogram      = 1'b0;
    time_param_sel = 2'd0;
    time_value     = 4'd0;

    #1;
    check("rst_running", running, 0);
    check("rst_expired", expired, 0);
    check("rst_tick", one_hz_enable, 0);
    check("rst_time_left", time_left, 0);
    step(2);
    reset = 1'b0;

    // Tick cadence: pulse after edges 4, 8, 12, 16, 20 only.
    for (int k = 1; k <= 20; k++) begin
      step(1);
      check($sformatf("tick_e%0d", k), one_hz_enable, (k % 4 == 0) ? 1 : 0);
    end

    // Default driver delay of 8 s -> 32 clocks.
    start_timer = 1'b1;
    interval    = 2'd1;
    step(1);
    start_timer = 1'b0;
    check("drv_running", running, 1);
    check("drv_expired", expired, 0);
    check("drv_load", time_left, 8);
    step(4);
    check("drv_first_dec", time_left, 7);
    wait_expired(40, n);
    check("drv_latency", n + 4, 32);
    check("drv_zero", time_left, 0);
    check("drv_not_running", running, 0);
    step(5);
    check("drv_expired_held", expired, 1);

    // Reprogram passenger delay to 3, then load it.
    reprogram      = 1'b1;
    time_param_sel = 2'd2;
    time_value     = 4'd3;
    step(1);
    reprogram = 1'b0;
    check("reprog_clears_expired", expired, 0);
    start_timer = 1'b1;
    interval    = 2'd2;
    step(1);
    start_timer = 1'b0;
    check("pas_load", time_left, 3);
    check("pas_running", running, 1);
    wait_expired(20, n);
    check("pas_latency", n, 12);

    // Arm delay untouched.
    start_timer = 1'b1;
    interval    = 2'd0;
    step(1);
    start_timer = 1'b0;
    check("arm_load", time_left, 6);
    check("arm_expired_low", expired, 0);
    step(4);
    check("arm_at_5", time_left, 5);

    // Abort during COUNT; also writes driver delay = 9.
    reprogram      = 1'b1;
    time_param_sel = 2'd1;
    time_value     = 4'd9;
    step(1);
    reprogram = 1'b0;
    check("abort_running", running, 0);
    check("abort_expired", expired, 0);
    check("abort_time_left", time_left, 0);

    // Reprogram and start together: no load, arm becomes 2.
    reprogram      = 1'b1;
    start_timer    = 1'b1;
    interval       = 2'd0;
    time_param_sel = 2'd0;
    time_value     = 4'd2;
    step(1);
    reprogram   = 1'b0;
    start_timer = 1'b0;
    check("prio_running", running, 0);
    check("prio_time_left", time_left, 0);
    start_timer = 1'b1;
    interval    = 2'd0;
    step(1);
    start_timer = 1'b0;
    check("prio_param_written", time_left, 2);

    // Zero-valued alarm delay expires straight from the load.
    reprogram      = 1'b1;
    time_param_sel = 2'd3;
    time_value     = 4'd0;
    step(1);
    reprogram   = 1'b0;
    start_timer = 1'b1;
    interval    = 2'd3;
    step(1);
    start_timer = 1'b0;
    check("zero_running", running, 0);
    check("zero_expired", expired, 1);
    check("zero_time_left", time_left, 0);

    // Restore arm = 6, run driver (9) down to 2, then restart with arm.
    reprogram      = 1'b1;
    time_param_sel = 2'd0;
    time_value     = 4'd6;
    step(1);
    reprogram   = 1'b0;
    start_timer = 1'b1;
    interval    = 2'd1;
    step(1);
    start_timer = 1'b0;
    check("drv9_load", time_left, 9);
    step(28);
    check("drv9_at_2", time_left, 2);
    step(2);
    start_timer = 1'b1;
    interval    = 2'd0;
    step(1);
    start_timer = 1'b0;
    check("restart_load", time_left, 6);
    step(3);
    check("restart_hold", time_left, 6);
    step(1);
    check("restart_dec", time_left, 5);

    // Asynchronous reset mid-cycle, no clock edge in between.
    #3;
    reset = 1'b1;
    #1;
    check("async_running", running, 0);
    check("async_time_left", time_left, 0);
    check("async_expired", expired, 0);
    step(1);
    reset       = 1'b0;
    start_timer = 1'b1;
    interval    = 2'd2;
    step(1);
    start_timer = 1'b0;
    check("async_param_default", time_left, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
